// File: rtl/mem_port_arbiter_if.sv
// Bundle between the IF/MEM pipeline stages, the arbiter, and the single-port memory.
// The arbiter uses the slave modport; the requesting/memory side uses master.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int BE_W = DATA_W / 8;

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ack;

    logic              dm_rd;
    logic              dm_wr;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [BE_W-1:0]   dm_be;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_ack;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [BE_W-1:0]   mem_be;
    logic [DATA_W-1:0] mem_rdata;

    logic              stall_if;
    logic              stall_mem;

    modport slave (
        input  if_req, if_addr, dm_rd, dm_wr, dm_addr, dm_wdata, dm_be, mem_rdata,
        output if_rdata, if_ack, dm_rdata, dm_ack,
        output mem_en, mem_we, mem_addr, mem_wdata, mem_be,
        output stall_if, stall_mem
    );

    modport master (
        output if_req, if_addr, dm_rd, dm_wr, dm_addr, dm_wdata, dm_be, mem_rdata,
        input  if_rdata, if_ack, dm_rdata, dm_ack,
        input  mem_en, mem_we, mem_addr, mem_wdata, mem_be,
        input  stall_if, stall_mem
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter for one fixed-latency single-port memory with pipeline stall outputs.
// Define FAIR_ARB_EN for round-robin arbitration; default is data-over-fetch priority.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    mem_port_arbiter_if.slave bus
);
    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT + 1);
    localparam logic [CNT_W-1:0] LAT_C = CNT_W'(MEM_LAT);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GRANT_IF = 2'd1,
        GRANT_DM = 2'd2,
        DONE     = 2'd3
    } state_e;

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              mem_en_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [BE_W-1:0]   mem_be_q;
    logic              if_ack_q;
    logic              dm_ack_q;
    logic              dm_req;
    logic              pick_dm;

    assign dm_req = bus.dm_rd | bus.dm_wr;
    assign cnt_d  = cnt_q + 1'b1;

`ifdef FAIR_ARB_EN
    // Set when the most recent grant went to the data port; reset favours data on the first tie.
    logic last_dm_q;

    assign pick_dm = dm_req & ~(bus.if_req & last_dm_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_dm_q <= 1'b0;
        end else if (state_q == IDLE && (dm_req || bus.if_req)) begin
            last_dm_q <= pick_dm;
        end
    end
`else
    assign pick_dm = dm_req;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            if_ack_q    <= 1'b0;
            dm_ack_q    <= 1'b0;
        end else begin
            mem_en_q <= 1'b0;
            if_ack_q <= 1'b0;
            dm_ack_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pick_dm) begin
                        state_q     <= GRANT_DM;
                        cnt_q       <= '0;
                        mem_en_q    <= 1'b1;
                        mem_we_q    <= bus.dm_wr;
                        mem_addr_q  <= bus.dm_addr;
                        mem_wdata_q <= bus.dm_wdata;
                        mem_be_q    <= bus.dm_wr ? bus.dm_be : '1;
                    end else if (bus.if_req) begin
                        state_q     <= GRANT_IF;
                        cnt_q       <= '0;
                        mem_en_q    <= 1'b1;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= bus.if_addr;
                        mem_wdata_q <= '0;
                        mem_be_q    <= '1;
                    end
                end
                GRANT_IF, GRANT_DM: begin
                    // Ack is registered one cycle early so it lines up with mem_rdata.
                    if (cnt_q == LAT_C) begin
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_d;
                        if (cnt_d == LAT_C) begin
                            if_ack_q <= (state_q == GRANT_IF);
                            dm_ack_q <= (state_q == GRANT_DM);
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_be    = mem_be_q;

    assign bus.if_ack    = if_ack_q;
    assign bus.dm_ack    = dm_ack_q;
    assign bus.if_rdata  = if_ack_q ? bus.mem_rdata : '0;
    assign bus.dm_rdata  = (dm_ack_q && !mem_we_q) ? bus.mem_rdata : '0;

    assign bus.stall_if  = bus.if_req & ~if_ack_q;
    assign bus.stall_mem = dm_req & ~dm_ack_q;
endmodule
